// File: rtl/cla8_share_ctrl.sv
// cla8_share_ctrl: round-robin sequencer that time-shares one 8-bit CLA adder among NREQ requesters.
// Optional macro CLA8_SHARE_OVF_EN adds rsp_ovf, a captured two's-complement overflow flag.
module cla8_share_ctrl #(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDW           = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_cin,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_sum,
`ifdef CLA8_SHARE_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic              rsp_cout
);

  localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      add_a_q, add_a_d;
  logic [7:0]      add_b_q, add_b_d;
  logic            add_cin_q, add_cin_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
`ifdef CLA8_SHARE_OVF_EN
  logic            rsp_ovf_q, rsp_ovf_d;

  function automatic logic ovf_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    return (a[7] == b[7]) && (s[7] != a[7]);
  endfunction
`endif

  logic            win_found_s;
  logic [IDW-1:0]  win_id_s;
  logic [NREQ-1:0] grant_s;
  logic [7:0]      sel_a_s;
  logic [7:0]      sel_b_s;
  logic            sel_cin_s;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found_s && req_valid[j] && (j == ((int'(rr_ptr_q) + k) % NREQ))) begin
          win_found_s = 1'b1;
          win_id_s    = IDW'(j);
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
  end

  // One-hot grant and operand select for the current winner.
  always_comb begin
    grant_s   = '0;
    sel_a_s   = 8'h00;
    sel_b_s   = 8'h00;
    sel_cin_s = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == win_id_s) begin
        sel_a_s    = req_a[j*8 +: 8];
        sel_b_s    = req_b[j*8 +: 8];
        sel_cin_s  = req_cin[j];
        grant_s[j] = (state_q == ST_IDLE) && win_found_s;
      end else begin
        grant_s[j] = 1'b0;
      end
    end
  end

  // Next-state and datapath update for the IDLE -> SETTLE -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
`ifdef CLA8_SHARE_OVF_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          add_a_d   = sel_a_s;
          add_b_d   = sel_b_s;
          add_cin_d = sel_cin_s;
          rsp_id_d  = win_id_s;
          rr_ptr_d  = win_id_s;
          cnt_d     = '0;
          state_d   = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // Sampling only after the window lets the gate-level ripple finish.
        if (cnt_q == CNT_LAST) begin
          rsp_sum_d   = add_sum;
          rsp_cout_d  = add_cout;
`ifdef CLA8_SHARE_OVF_EN
          rsp_ovf_d   = ovf_of(add_a_q, add_b_q, add_sum);
`endif
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= PTR_RST;
      cnt_q       <= '0;
      add_a_q     <= 8'h00;
      add_b_q     <= 8'h00;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= 8'h00;
      rsp_cout_q  <= 1'b0;
`ifdef CLA8_SHARE_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
`ifdef CLA8_SHARE_OVF_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign req_ready = grant_s;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef CLA8_SHARE_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_cla8_share_ctrl.sv
// Self-checking bench for cla8_share_ctrl: directed table, hand sequences and randomized transactions.
// The shared adder is modelled with a one-cycle unsettled window that produces wrong results.
module tb_cla8_share_ctrl;

  localparam int NREQ = 4;
  localparam int SC   = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic              add_cin;
  logic [7:0]        add_sum;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
`ifdef CLA8_SHARE_OVF_EN
  logic              rsp_ovf;
`endif

  cla8_share_ctrl #(.NREQ(NREQ), .SETTLE_CYCLES(SC), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
`ifdef CLA8_SHARE_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Adder model: output is garbage until operands have been stable across one edge.
  logic [16:0] ops_prev = 17'd0;
  logic [8:0]  true_res;
  assign true_res = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign {add_cout, add_sum} = (ops_prev == {add_a, add_b, add_cin}) ? true_res : ~true_res;
  always @(posedge clk) ops_prev <= {add_a, add_b, add_cin};

  int n_vec = 0;
  int n_bad = 0;
  int last_served = NREQ - 1;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    bit         mangle;
    int         stall;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last_served + k) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int u, s, sa, sb;
    u  = int'(a) + int'(b) + int'(cin);
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    s  = sa + sb + int'(cin);
    return {((s > 127) || (s < -128)), (u > 255), u[7:0]};
  endfunction

  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ*8-1:0] av,
                         input logic [NREQ*8-1:0] bv, input logic [NREQ-1:0] cv,
                         input bit mangle, input int stall, input bit chain, input bit hold,
                         input int exp_id, input logic [7:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf);
    int lat, nxt;
    logic [7:0] ea, eb;
    logic ec;
    ea = av[exp_id*8 +: 8];
    eb = bv[exp_id*8 +: 8];
    ec = cv[exp_id];
    if (!chain) @(negedge clk);
    req_valid = mask; req_a = av; req_b = bv; req_cin = cv;
    rsp_ready = (stall == 0);
    #1;
    check("grant", {28'd0, req_ready}, 32'd1 << exp_id);
    @(posedge clk);
    last_served = exp_id;
    @(negedge clk);
    if (mangle) begin
      req_a   = req_a ^ {NREQ{8'h89}};
      req_b   = ~req_b;
      req_cin = ~req_cin;
    end
    #1;
    check("add_a", {24'd0, add_a}, {24'd0, ea});
    check("add_b", {24'd0, add_b}, {24'd0, eb});
    check("add_cin", {31'd0, add_cin}, {31'd0, ec});
    check("settle_ready", {28'd0, req_ready}, 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    check("latency", lat, SC + 1);
    if (!rsp_valid) begin
      req_valid = '0;
      rsp_ready = 1'b1;
      return;
    end
    check("rsp_id", {30'd0, rsp_id}, exp_id);
    check("rsp_sum", {24'd0, rsp_sum}, {24'd0, exp_sum});
    check("rsp_cout", {31'd0, rsp_cout}, {31'd0, exp_cout});
`ifdef CLA8_SHARE_OVF_EN
    check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_sum", {24'd0, rsp_sum}, {24'd0, exp_sum});
      check("stall_id", {30'd0, rsp_id}, exp_id);
      check("stall_cout", {31'd0, rsp_cout}, {31'd0, exp_cout});
      check("stall_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    check("hs_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk); #1;
    check("post_valid", {31'd0, rsp_valid}, 32'd0);
    check("held_a", {24'd0, add_a}, {24'd0, ea});
    nxt = rr_pick(req_valid);
    check("next_grant", {28'd0, req_ready}, (nxt < 0) ? 32'd0 : (32'd1 << nxt));
    if (!hold) req_valid = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ*8-1:0] av, bv;
    logic [NREQ-1:0]   cv, mask;
    logic [9:0]        r;
    int                w;
    int                rr_exp[5];

    tbl[0] = '{0, 8'h3C, 8'h45, 1'b0, 1'b0, 0, 8'h81, 1'b0, 1'b1};
    tbl[1] = '{2, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h10, 8'h05, 1'b0, 1'b1, 0, 8'h15, 1'b0, 1'b0};
    tbl[3] = '{3, 8'h80, 8'h80, 1'b0, 1'b0, 5, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{1, 8'h7F, 8'h00, 1'b1, 1'b0, 2, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0};
    rr_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_add", {15'd0, add_a, add_b, add_cin}, 32'd0);
    check("rst_rsp", {20'd0, rsp_valid, rsp_id, rsp_sum, rsp_cout}, 32'd0);
    rst = 1'b0;

    // Round-robin with all four requesters held valid.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        av[i*8 +: 8] = 8'(8'h11 * (i + 1) + t);
        bv[i*8 +: 8] = 8'(8'h20 + i);
      end
      cv = 4'b0101;
      w = rr_pick(4'b1111);
      check("rr_order", w, rr_exp[t]);
      r = ref_add(av[w*8 +: 8], bv[w*8 +: 8], cv[w]);
      run_txn(4'b1111, av, bv, cv, 1'b0, 0, (t != 0), (t != 4), w, r[7:0], r[8], r[9]);
    end

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      av = {$urandom, $urandom} & {NREQ*8{1'b1}};
      bv = {$urandom, $urandom} & {NREQ*8{1'b1}};
      cv = 4'($urandom);
      av[tbl[t].id*8 +: 8] = tbl[t].a;
      bv[tbl[t].id*8 +: 8] = tbl[t].b;
      cv[tbl[t].id]        = tbl[t].cin;
      run_txn(4'b0001 << tbl[t].id, av, bv, cv, tbl[t].mangle, tbl[t].stall, 1'b0, 1'b0,
              tbl[t].id, tbl[t].sum, tbl[t].cout, tbl[t].ovf);
    end

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      av   = {$urandom, $urandom} & {NREQ*8{1'b1}};
      bv   = {$urandom, $urandom} & {NREQ*8{1'b1}};
      cv   = 4'($urandom);
      mask = 4'($urandom_range(1, 15));
      w    = rr_pick(mask);
      r    = ref_add(av[w*8 +: 8], bv[w*8 +: 8], cv[w]);
      run_txn(mask, av, bv, cv, 1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0,
              w, r[7:0], r[8], r[9]);
    end

    // Reset during SETTLE aborts the transaction.
    @(negedge clk);
    req_valid = 4'b0100; req_a = {4{8'h5A}}; req_b = {4{8'h33}}; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk); #1;
    check("midrst_ready", {28'd0, req_ready}, 32'd0);
    check("midrst_add", {15'd0, add_a, add_b, add_cin}, 32'd0);
    check("midrst_rsp", {20'd0, rsp_valid, rsp_id, rsp_sum, rsp_cout}, 32'd0);
    rst = 1'b0;
    last_served = NREQ - 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("no_stale_valid", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 4'b1111;
    #1;
    check("post_rst_grant", {28'd0, req_ready}, 32'd1);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
